// File: rtl/traffic_conflict_monitor.sv
// traffic_conflict_monitor: light-bus safety stage; optional stuck-pattern check enabled by MONITOR_STUCK_CHECK_EN
module traffic_conflict_monitor #(
  parameter int FILTER      = 2,
  parameter int START_TICKS = 4,
  parameter int STUCK_LIMIT = 16,
  parameter int FLASH_DIV   = 2
) (
  input  logic       clk,
  input  logic       rst_a,
  input  logic       tick_en,
  input  logic [2:0] mn_in,
  input  logic [2:0] ms_in,
  input  logic [2:0] le_in,
  input  logic [2:0] lw_in,
  input  logic       fault_clr,
  output logic [2:0] mn_out,
  output logic [2:0] ms_out,
  output logic [2:0] le_out,
  output logic [2:0] lw_out,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic       flash
);
  localparam logic [11:0] RED4 = 12'b100100100100;
  localparam int VW = $clog2(FILTER + 1);
  localparam int SW = $clog2(START_TICKS + 1);
  localparam int FW = $clog2(FLASH_DIV + 1);
  localparam logic [VW-1:0] V_LAST = VW'(FILTER - 1);
  localparam logic [SW-1:0] S_LAST = SW'(START_TICKS - 1);
  localparam logic [FW-1:0] F_LAST = FW'(FLASH_DIV - 1);
  typedef enum logic [1:0] {STARTUP = 2'd0, MONITOR = 2'd1, FAULT = 2'd2} state_t;
  state_t state_q, state_d;
  logic [11:0] lights, out_q, out_d;
  logic [VW-1:0] viol_cnt_q, viol_cnt_d;
  logic [SW-1:0] start_cnt_q, start_cnt_d;
  logic [FW-1:0] flash_cnt_q, flash_cnt_d;
  logic flash_q, flash_d;
  logic [1:0] code_q, code_d;
  logic [2:0] nonred;
  logic invalid, conflict, viol, viol_fire, stuck_fire, enter, leave, to_mon, flash_tick;
  assign lights   = {mn_in, ms_in, le_in, lw_in};
  assign invalid  = !($onehot(mn_in) && $onehot(ms_in) && $onehot(le_in) && $onehot(lw_in));
  assign nonred   = 3'(mn_in != 3'b100) + 3'(ms_in != 3'b100) + 3'(le_in != 3'b100) + 3'(lw_in != 3'b100);
  assign conflict = nonred > 3'd1;
  assign viol      = invalid | conflict;
  assign viol_fire = viol && viol_cnt_q == V_LAST;
  assign enter      = state_q != FAULT && (viol_fire || stuck_fire);
  assign leave      = state_q == FAULT && fault_clr && !viol;
  assign to_mon     = state_q == STARTUP && tick_en && !enter && start_cnt_q == S_LAST;
  assign flash_tick = state_q == FAULT && tick_en && !leave;
`ifdef MONITOR_STUCK_CHECK_EN
  localparam int KW = $clog2(STUCK_LIMIT + 1);
  logic [11:0] prev_q;
  logic [KW-1:0] stuck_cnt_q, stuck_cnt_d;
  logic same;
  assign same       = lights == prev_q;
  assign stuck_fire = state_q == MONITOR && tick_en && same && stuck_cnt_q == KW'(STUCK_LIMIT - 1);
  // Stuck counter restarts on any input change or MONITOR entry and counts unchanged ticks in MONITOR
  always_comb
    stuck_cnt_d = (!same || to_mon) ? '0 : (state_q == MONITOR && tick_en) ? stuck_cnt_q + 1'b1 : stuck_cnt_q;
  // Previous light vector and stuck counter registers
  always_ff @(posedge clk or posedge rst_a)
    if (rst_a) begin
      prev_q      <= RED4;
      stuck_cnt_q <= '0;
    end else begin
      prev_q      <= lights;
      stuck_cnt_q <= stuck_cnt_d;
    end
`else
  logic unused_stuck;
  assign unused_stuck = STUCK_LIMIT != 0;
  assign stuck_fire   = 1'b0;
`endif
  // Next state, counters and lamp drive; fault entry outranks every other transition
  always_comb begin
    state_d     = enter ? FAULT : leave ? STARTUP : to_mon ? MONITOR : state_q;
    viol_cnt_d  = !viol ? '0 : (viol_cnt_q == V_LAST) ? viol_cnt_q : viol_cnt_q + 1'b1;
    start_cnt_d = (leave || to_mon) ? '0 : (state_q == STARTUP && tick_en && !enter) ? start_cnt_q + 1'b1 : start_cnt_q;
    flash_cnt_d = (enter || leave) ? '0 : flash_tick ? ((flash_cnt_q == F_LAST) ? '0 : flash_cnt_q + 1'b1) : flash_cnt_q;
    flash_d     = enter ? 1'b1 : leave ? 1'b0 : (flash_tick && flash_cnt_q == F_LAST) ? !flash_q : flash_q;
    code_d      = enter ? (invalid ? 2'b01 : conflict ? 2'b10 : 2'b11) : leave ? 2'b00 : code_q;
    out_d       = (state_d == FAULT) ? (flash_d ? RED4 : 12'h000) : (state_q == MONITOR && !viol) ? lights : RED4;
  end
  // State and datapath registers
  always_ff @(posedge clk or posedge rst_a)
    if (rst_a) begin
      state_q     <= STARTUP;
      viol_cnt_q  <= '0;
      start_cnt_q <= '0;
      flash_cnt_q <= '0;
      flash_q     <= 1'b0;
      code_q      <= 2'b00;
      out_q       <= RED4;
    end else begin
      state_q     <= state_d;
      viol_cnt_q  <= viol_cnt_d;
      start_cnt_q <= start_cnt_d;
      flash_cnt_q <= flash_cnt_d;
      flash_q     <= flash_d;
      code_q      <= code_d;
      out_q       <= out_d;
    end
  assign {mn_out, ms_out, le_out, lw_out} = out_q;
  assign fault      = state_q == FAULT;
  assign fault_code = code_q;
  assign flash      = flash_q;
endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// tb_traffic_conflict_monitor: directed scenarios plus randomized run against a rule-level model
module tb_traffic_conflict_monitor;
  localparam int FILTER = 2;
  localparam int START_TICKS = 4;
  localparam int STUCK_LIMIT = 16;
  localparam int FLASH_DIV = 2;
  localparam logic [11:0] RED4 = 12'b100_100_100_100;
  localparam logic [11:0] NG   = 12'b001_100_100_100;
  localparam logic [11:0] SG   = 12'b100_001_100_100;
  localparam logic [11:0] CONF = 12'b001_100_001_100;
  localparam logic [11:0] INV  = 12'b011_100_100_100;
  logic clk = 1'b0, rst_a = 1'b0, tick_en = 1'b0, fault_clr = 1'b0;
  logic [2:0] mn_in = 3'b100, ms_in = 3'b100, le_in = 3'b100, lw_in = 3'b100;
  logic [2:0] mn_out, ms_out, le_out, lw_out;
  logic fault, flash;
  logic [1:0] fault_code;
  int n_tests = 0, n_fail = 0;
  int m_st, m_run, m_ticks, m_fcnt, m_stuck;
  logic m_flash;
  logic [1:0] m_code;
  logic [11:0] m_out, m_prev;
  traffic_conflict_monitor #(.FILTER(FILTER), .START_TICKS(START_TICKS), .STUCK_LIMIT(STUCK_LIMIT), .FLASH_DIV(FLASH_DIV)) dut (
    .clk(clk), .rst_a(rst_a), .tick_en(tick_en),
    .mn_in(mn_in), .ms_in(ms_in), .le_in(le_in), .lw_in(lw_in),
    .fault_clr(fault_clr),
    .mn_out(mn_out), .ms_out(ms_out), .le_out(le_out), .lw_out(lw_out),
    .fault(fault), .fault_code(fault_code), .flash(flash)
  );
  initial forever #5 clk = ~clk;
  function automatic logic [15:0] obs();
    return {mn_out, ms_out, le_out, lw_out, fault, fault_code, flash};
  endfunction
  function automatic logic [15:0] model_v();
    return {m_out, m_st == 2, m_code, m_flash};
  endfunction
  function automatic void model_reset();
    m_st = 0; m_run = 0; m_ticks = 0; m_fcnt = 0; m_stuck = 0;
    m_flash = 1'b0; m_code = 2'b00; m_out = RED4; m_prev = RED4;
  endfunction
  task automatic model_edge();
    logic [11:0] v;
    logic [2:0] b;
    int nonred, st0;
    logic inv, viol, ent_v, ent_s, to_mon;
    v = {mn_in, ms_in, le_in, lw_in};
    nonred = 0; inv = 1'b0; ent_s = 1'b0; to_mon = 1'b0; st0 = m_st;
    for (int i = 0; i < 4; i++) begin
      b = v[i*3 +: 3];
      if ($countones(b) != 1) inv = 1'b1;
      if (b != 3'b100) nonred++;
    end
    viol = inv || nonred > 1;
    ent_v = viol && m_run >= FILTER - 1;
`ifdef MONITOR_STUCK_CHECK_EN
    ent_s = m_st == 1 && tick_en && v == m_prev && m_stuck == STUCK_LIMIT - 1;
`endif
    m_run = viol ? m_run + 1 : 0;
    if (m_st != 2 && (ent_v || ent_s)) begin
      m_st = 2; m_code = inv ? 2'd1 : (nonred > 1) ? 2'd2 : 2'd3;
      m_flash = 1'b1; m_fcnt = 0; m_out = RED4;
    end else if (m_st == 0) begin
      m_out = RED4;
      if (tick_en) begin
        m_ticks++;
        if (m_ticks == START_TICKS) begin m_st = 1; m_ticks = 0; to_mon = 1'b1; end
      end
    end else if (m_st == 1) begin
      m_out = viol ? RED4 : v;
    end else if (fault_clr && !viol) begin
      m_st = 0; m_ticks = 0; m_code = 2'd0; m_flash = 1'b0; m_out = RED4;
    end else begin
      if (tick_en) begin
        m_fcnt++;
        if (m_fcnt == FLASH_DIV) begin m_fcnt = 0; m_flash = !m_flash; end
      end
      m_out = m_flash ? RED4 : 12'h000;
    end
    if (v != m_prev || to_mon) m_stuck = 0;
    else if (st0 == 1 && tick_en) m_stuck++;
    m_prev = v;
  endtask
  task automatic set_in(input logic [11:0] v, input logic t, input logic c);
    {mn_in, ms_in, le_in, lw_in} = v;
    tick_en = t;
    fault_clr = c;
  endtask
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask
  task automatic do_reset();
    set_in(RED4, 1'b0, 1'b0);
    rst_a = 1'b1;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst_a = 1'b0;
  endtask
  task automatic go_monitor(input logic [11:0] v);
    do_reset();
    set_in(v, 1'b0, 1'b0);
    for (int i = 0; i < START_TICKS; i++) begin
      tick_en = 1'b1; step();
      tick_en = 1'b0; step();
    end
  endtask
  task automatic test_reset();
    #2 rst_a = 1'b1;
    model_reset();
    #1;
    n_tests++;
    if (obs() !== {RED4, 4'b0000}) begin n_fail++; $display("FAIL reset_async got=%h want=%h", obs(), {RED4, 4'b0000}); end
    @(posedge clk); @(posedge clk); #1;
    rst_a = 1'b0;
    step();
    n_tests++;
    if (obs() !== {RED4, 4'b0000}) begin n_fail++; $display("FAIL reset_release got=%h want=%h", obs(), {RED4, 4'b0000}); end
  endtask
  task automatic test_startup();
    do_reset();
    set_in(NG, 1'b0, 1'b0);
    for (int i = 1; i <= START_TICKS; i++) begin
      tick_en = 1'b1; step();
      n_tests++;
      if (obs() !== {RED4, 4'b0000}) begin n_fail++; $display("FAIL startup_tick%0d got=%h want=%h", i, obs(), {RED4, 4'b0000}); end
      tick_en = 1'b0; step();
      if (i < START_TICKS) begin
        n_tests++;
        if (obs() !== {RED4, 4'b0000}) begin n_fail++; $display("FAIL startup_idle%0d got=%h want=%h", i, obs(), {RED4, 4'b0000}); end
      end
    end
    n_tests++;
    if (obs() !== {NG, 4'b0000}) begin n_fail++; $display("FAIL startup_pass got=%h want=%h", obs(), {NG, 4'b0000}); end
  endtask
  task automatic test_transient();
    set_in(CONF, 1'b0, 1'b0); step();
    n_tests++;
    if (obs() !== {RED4, 4'b0000}) begin n_fail++; $display("FAIL transient_red got=%h want=%h", obs(), {RED4, 4'b0000}); end
    set_in(NG, 1'b0, 1'b0); step();
    n_tests++;
    if (obs() !== {NG, 4'b0000}) begin n_fail++; $display("FAIL transient_resume got=%h want=%h", obs(), {NG, 4'b0000}); end
  endtask
  task automatic test_conflict_fault();
    set_in(CONF, 1'b0, 1'b0); step();
    n_tests++;
    if (obs() !== {RED4, 4'b0000}) begin n_fail++; $display("FAIL conflict_first got=%h want=%h", obs(), {RED4, 4'b0000}); end
    step();
    n_tests++;
    if (obs() !== {RED4, 4'b1101}) begin n_fail++; $display("FAIL conflict_entry got=%h want=%h", obs(), {RED4, 4'b1101}); end
    set_in(NG, 1'b1, 1'b0); step();
    n_tests++;
    if (obs() !== {RED4, 4'b1101}) begin n_fail++; $display("FAIL conflict_tick1 got=%h want=%h", obs(), {RED4, 4'b1101}); end
    tick_en = 1'b0; step();
    tick_en = 1'b1; step();
    n_tests++;
    if (obs() !== {12'h000, 4'b1100}) begin n_fail++; $display("FAIL conflict_tick2 got=%h want=%h", obs(), {12'h000, 4'b1100}); end
    tick_en = 1'b0; step();
    tick_en = 1'b1; step();
    tick_en = 1'b0; step();
    tick_en = 1'b1; step();
    tick_en = 1'b0;
    n_tests++;
    if (obs() !== {RED4, 4'b1101}) begin n_fail++; $display("FAIL conflict_tick4 got=%h want=%h", obs(), {RED4, 4'b1101}); end
  endtask
  task automatic test_invalid_clear();
    go_monitor(NG);
    set_in(INV, 1'b0, 1'b0); step(); step();
    n_tests++;
    if (obs() !== {RED4, 4'b1011}) begin n_fail++; $display("FAIL invalid_entry got=%h want=%h", obs(), {RED4, 4'b1011}); end
    set_in(INV, 1'b0, 1'b1); step();
    n_tests++;
    if (obs() !== {RED4, 4'b1011}) begin n_fail++; $display("FAIL invalid_clr_ignored got=%h want=%h", obs(), {RED4, 4'b1011}); end
    set_in(NG, 1'b0, 1'b1); step();
    n_tests++;
    if (obs() !== {RED4, 4'b0000}) begin n_fail++; $display("FAIL invalid_cleared got=%h want=%h", obs(), {RED4, 4'b0000}); end
    fault_clr = 1'b0;
    for (int i = 1; i <= START_TICKS; i++) begin
      tick_en = 1'b1; step();
      n_tests++;
      if (obs() !== {RED4, 4'b0000}) begin n_fail++; $display("FAIL restart_tick%0d got=%h want=%h", i, obs(), {RED4, 4'b0000}); end
      tick_en = 1'b0; step();
    end
    n_tests++;
    if (obs() !== {NG, 4'b0000}) begin n_fail++; $display("FAIL restart_pass got=%h want=%h", obs(), {NG, 4'b0000}); end
  endtask
  task automatic test_stuck();
    go_monitor(SG);
    for (int i = 1; i < STUCK_LIMIT; i++) begin
      tick_en = 1'b1; step();
      tick_en = 1'b0; step();
    end
    n_tests++;
    if (obs() !== {SG, 4'b0000}) begin n_fail++; $display("FAIL stuck_before got=%h want=%h", obs(), {SG, 4'b0000}); end
`ifdef MONITOR_STUCK_CHECK_EN
    tick_en = 1'b1; step();
    tick_en = 1'b0;
    n_tests++;
    if (obs() !== {RED4, 4'b1111}) begin n_fail++; $display("FAIL stuck_entry got=%h want=%h", obs(), {RED4, 4'b1111}); end
`else
    for (int i = STUCK_LIMIT; i <= 100; i++) begin
      tick_en = 1'b1; step();
      tick_en = 1'b0; step();
    end
    n_tests++;
    if (obs() !== {SG, 4'b0000}) begin n_fail++; $display("FAIL stuck_disabled got=%h want=%h", obs(), {SG, 4'b0000}); end
`endif
  endtask
  task automatic test_reset_mid_fault();
    go_monitor(NG);
    set_in(CONF, 1'b0, 1'b0); step(); step();
    set_in(NG, 1'b1, 1'b0); step();
    tick_en = 1'b0;
    n_tests++;
    if (obs() !== {RED4, 4'b1101}) begin n_fail++; $display("FAIL midfault_pre got=%h want=%h", obs(), {RED4, 4'b1101}); end
    #2 rst_a = 1'b1;
    model_reset();
    #1;
    n_tests++;
    if (obs() !== {RED4, 4'b0000}) begin n_fail++; $display("FAIL midfault_reset got=%h want=%h", obs(), {RED4, 4'b0000}); end
    @(posedge clk); #1;
    rst_a = 1'b0;
    step();
    n_tests++;
    if (obs() !== {RED4, 4'b0000}) begin n_fail++; $display("FAIL midfault_startup got=%h want=%h", obs(), {RED4, 4'b0000}); end
  endtask
  task automatic test_random();
    logic [11:0] cur, bad, pat;
    int bad_left, k;
    do_reset();
    cur = NG; bad = RED4; bad_left = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) < 3) begin
        pat = RED4;
        k = $urandom_range(0, 4);
        if (k < 4) pat[k*3 +: 3] = ($urandom_range(0, 1) == 0) ? 3'b001 : 3'b010;
        cur = pat;
      end
      if (bad_left == 0 && $urandom_range(0, 99) < 6) begin
        bad_left = $urandom_range(1, 3);
        bad = ($urandom_range(0, 1) == 0) ? 12'($urandom()) : (cur | 12'b001_001_000_000) & 12'b011_111_100_100;
      end
      if (bad_left > 0) begin
        set_in(bad, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 5) == 0));
        bad_left--;
      end else
        set_in(cur, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 5) == 0));
      step();
      n_tests++;
      if (obs() !== model_v()) begin n_fail++; $display("FAIL random_cycle%0d got=%h want=%h", n, obs(), model_v()); end
    end
  endtask
  initial begin
    test_reset();
    test_startup();
    test_transient();
    test_conflict_fault();
    test_invalid_clear();
    test_stuck();
    test_reset_mid_fault();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
